// File: rtl/uu_acmac_tx_mem_fetch_if.sv
// Command, memory-port and output-stream bundle for the TX frame buffer fetch engine.
// master = fetch engine side, slave = command source / memory / downstream side.
interface uu_acmac_tx_mem_fetch_if #(
    parameter int unsigned ADDR_W = 14,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LEN_W  = 16
);
    logic              cmd_start;
    logic [ADDR_W-1:0] cmd_base;
    logic [LEN_W-1:0]  cmd_len;
    logic              cmd_busy;
    logic              cmd_done;
    logic              cmd_err;
    logic              abort;
    logic              mem_en;
    logic              mem_wen;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic [2:0]        out_bytes;

    modport master (
        input  cmd_start, cmd_base, cmd_len, abort, mem_rdata, out_ready,
        output cmd_busy, cmd_done, cmd_err, mem_en, mem_wen, mem_addr, mem_wdata,
               out_valid, out_data, out_last, out_bytes
    );

    modport slave (
        output cmd_start, cmd_base, cmd_len, abort, mem_rdata, out_ready,
        input  cmd_busy, cmd_done, cmd_err, mem_en, mem_wen, mem_addr, mem_wdata,
               out_valid, out_data, out_last, out_bytes
    );
endinterface

// File: rtl/uu_acmac_tx_mem_fetch.sv
// TX frame buffer read initiator: sequential word fetch into a 2-entry output buffer.
// Optional TX_FETCH_BYTE_SWAP_EN byte-reverses each word for big-endian consumers.
module uu_acmac_tx_mem_fetch #(
    parameter int unsigned ADDR_W    = 14,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MEM_DEPTH = 208,
    parameter int unsigned LEN_W     = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    uu_acmac_tx_mem_fetch_if.master bus
);
    localparam int unsigned CNT_W = LEN_W - 1;
    localparam int unsigned BYT_W = 3;

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

    state_t r_state, w_state_n;
    logic   r_busy, w_busy_n;
    logic   r_done, w_done_n;
    logic   r_err, w_err_n;

    logic [ADDR_W-1:0] r_addr;
    logic [CNT_W-1:0]  r_nwords;
    logic [CNT_W-1:0]  r_issue_cnt;
    logic [BYT_W-1:0]  r_last_bytes;
    logic              r_rd_pend;
    logic              r_pend_last;

    logic              r_out_valid;
    logic              r_out_last;
    logic [DATA_W-1:0] r_out_data;
    logic [BYT_W-1:0]  r_out_bytes;
    logic              r_sk_valid;
    logic              r_sk_last;
    logic [DATA_W-1:0] r_sk_data;
    logic [BYT_W-1:0]  r_sk_bytes;

    logic              w_cmd_illegal;
    logic              w_accept;
    logic              w_flush;
    logic              w_pop;
    logic              w_issue;
    logic              w_issue_last;
    logic [1:0]        w_occ;
    logic [CNT_W-1:0]  w_cmd_nwords;
    logic [BYT_W-1:0]  w_cmd_last_bytes;
    logic [ADDR_W-1:0] w_addr_inc;
    logic [DATA_W-1:0] w_new_data;
    logic [BYT_W-1:0]  w_new_bytes;

    assign w_cmd_illegal = (bus.cmd_len == '0) ||
                           (bus.cmd_len > LEN_W'(4 * MEM_DEPTH)) ||
                           (bus.cmd_base >= ADDR_W'(MEM_DEPTH));
    assign w_cmd_nwords     = CNT_W'(bus.cmd_len[LEN_W-1:2]) + CNT_W'(|bus.cmd_len[1:0]);
    assign w_cmd_last_bytes = (bus.cmd_len[1:0] == 2'd0) ? BYT_W'(4) : BYT_W'(bus.cmd_len[1:0]);
    assign w_accept = (r_state == S_IDLE) && bus.cmd_start && !w_cmd_illegal;
    assign w_flush  = (r_state != S_IDLE) && bus.abort;
    assign w_pop    = r_out_valid && bus.out_ready;

    // Words that will still occupy the buffer at the end of this cycle; a read issued now
    // lands one cycle later, so it is only safe while this stays below the buffer depth.
    assign w_occ        = 2'(r_out_valid && !bus.out_ready) + 2'(r_sk_valid) + 2'(r_rd_pend);
    assign w_issue      = (r_state == S_FETCH) && !bus.abort && (w_occ < 2'd2);
    assign w_issue_last = (r_issue_cnt == r_nwords - CNT_W'(1));
    assign w_addr_inc   = (r_addr == ADDR_W'(MEM_DEPTH - 1)) ? '0 : r_addr + ADDR_W'(1);
    assign w_new_bytes  = r_pend_last ? r_last_bytes : BYT_W'(4);

`ifdef TX_FETCH_BYTE_SWAP_EN
    assign w_new_data = {bus.mem_rdata[7:0], bus.mem_rdata[15:8],
                         bus.mem_rdata[23:16], bus.mem_rdata[31:24]};
`else
    assign w_new_data = bus.mem_rdata;
`endif

    // FSM state and registered status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_busy  <= w_busy_n;
            r_done  <= w_done_n;
            r_err   <= w_err_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_busy_n  = r_busy;
        w_done_n  = 1'b0;
        w_err_n   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (bus.cmd_start) begin
                    if (w_cmd_illegal) begin
                        w_err_n = 1'b1;
                    end else begin
                        w_state_n = S_FETCH;
                        w_busy_n  = 1'b1;
                    end
                end
            end
            S_FETCH: begin
                if (bus.abort) begin
                    w_state_n = S_IDLE;
                    w_busy_n  = 1'b0;
                end else if (w_issue && w_issue_last) begin
                    w_state_n = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Abort beats a coincident final handshake: no done pulse.
                if (bus.abort) begin
                    w_state_n = S_IDLE;
                    w_busy_n  = 1'b0;
                end else if (w_pop && r_out_last) begin
                    w_state_n = S_DONE;
                    w_busy_n  = 1'b0;
                    w_done_n  = 1'b1;
                end
            end
            S_DONE: begin
                w_state_n = S_IDLE;
                w_busy_n  = 1'b0;
            end
            default: begin
                w_state_n = S_IDLE;
                w_busy_n  = 1'b0;
            end
        endcase
    end

    // Address/count tracking, read pipeline and head+skid output buffer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr       <= '0;
            r_nwords     <= '0;
            r_issue_cnt  <= '0;
            r_last_bytes <= '0;
            r_rd_pend    <= 1'b0;
            r_pend_last  <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_last   <= 1'b0;
            r_out_data   <= '0;
            r_out_bytes  <= '0;
            r_sk_valid   <= 1'b0;
            r_sk_last    <= 1'b0;
            r_sk_data    <= '0;
            r_sk_bytes   <= '0;
        end else if (w_flush) begin
            r_rd_pend   <= 1'b0;
            r_pend_last <= 1'b0;
            r_out_valid <= 1'b0;
            r_sk_valid  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr       <= bus.cmd_base;
                r_nwords     <= w_cmd_nwords;
                r_last_bytes <= w_cmd_last_bytes;
                r_issue_cnt  <= '0;
            end else if (w_issue) begin
                r_addr      <= w_addr_inc;
                r_issue_cnt <= r_issue_cnt + CNT_W'(1);
            end
            r_rd_pend   <= w_issue;
            r_pend_last <= w_issue && w_issue_last;

            if (!r_out_valid || w_pop) begin
                if (r_sk_valid) begin
                    r_out_valid <= 1'b1;
                    r_out_data  <= r_sk_data;
                    r_out_last  <= r_sk_last;
                    r_out_bytes <= r_sk_bytes;
                    r_sk_valid  <= r_rd_pend;
                    if (r_rd_pend) begin
                        r_sk_data  <= w_new_data;
                        r_sk_last  <= r_pend_last;
                        r_sk_bytes <= w_new_bytes;
                    end
                end else begin
                    r_out_valid <= r_rd_pend;
                    if (r_rd_pend) begin
                        r_out_data  <= w_new_data;
                        r_out_last  <= r_pend_last;
                        r_out_bytes <= w_new_bytes;
                    end
                end
            end else if (r_rd_pend) begin
                r_sk_valid <= 1'b1;
                r_sk_data  <= w_new_data;
                r_sk_last  <= r_pend_last;
                r_sk_bytes <= w_new_bytes;
            end
        end
    end

    assign bus.cmd_busy  = r_busy;
    assign bus.cmd_done  = r_done;
    assign bus.cmd_err   = r_err;
    assign bus.mem_en    = w_issue;
    assign bus.mem_wen   = 1'b0;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = '0;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_last  = r_out_last;
    assign bus.out_bytes = r_out_bytes;
endmodule

// File: tb/tb_uu_acmac_tx_mem_fetch.sv
// Self-checking bench for uu_acmac_tx_mem_fetch: vector table plus abort/reset sequences.
// Build with TX_FETCH_BYTE_SWAP_EN defined to check the byte-reversed data path.
module tb_uu_acmac_tx_mem_fetch;
    localparam int unsigned ADDR_W    = 14;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned MEM_DEPTH = 208;
    localparam int unsigned LEN_W     = 16;
    localparam int          BUDGET    = 1000;
    localparam int          NVEC      = 10;
`ifdef TX_FETCH_BYTE_SWAP_EN
    localparam logic [31:0] SWAP_WORD = 32'h44332211;
`else
    localparam logic [31:0] SWAP_WORD = 32'h11223344;
`endif

    typedef struct {
        int          base;
        int          len;
        bit          rdy_toggle;
        bit          poke;
        bit          exp_err;
        int          exp_n;
        int          exp_lb;
        bit          chk_first;
        logic [31:0] exp_first;
    } vec_t;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    logic [DATA_W-1:0] mem [MEM_DEPTH];
    vec_t vecs [NVEC];

    uu_acmac_tx_mem_fetch_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

    uu_acmac_tx_mem_fetch #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_DEPTH(MEM_DEPTH), .LEN_W(LEN_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One-cycle registered-read memory; drives 0 when not enabled
    always @(posedge clk) begin
        if (bus.mem_en && (bus.mem_addr < ADDR_W'(MEM_DEPTH)))
            bus.mem_rdata <= mem[bus.mem_addr];
        else
            bus.mem_rdata <= '0;
    end

    function automatic logic [31:0] fmt(input logic [31:0] d);
`ifdef TX_FETCH_BYTE_SWAP_EN
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
`else
        return d;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic start_cmd(input int base, input int len);
        bus.cmd_start = 1'b1;
        bus.cmd_base  = ADDR_W'(base);
        bus.cmd_len   = LEN_W'(len);
        @(negedge clk);
        bus.cmd_start = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int k;
        int iss;
        int first;
        bit hold;
        bit rdy;
        logic [31:0] hold_d;
        k = 0; iss = 0; first = -1; hold = 1'b0; hold_d = '0;
        start_cmd(v.base, v.len);
        if (v.exp_err) begin
            #1;
            chk({tag, " err pulse"}, 32'(bus.cmd_err), 32'd1);
            chk({tag, " err busy"}, 32'(bus.cmd_busy), 32'd0);
            chk({tag, " err mem_en"}, 32'(bus.mem_en), 32'd0);
            @(negedge clk); #1;
            chk({tag, " err end"}, 32'(bus.cmd_err), 32'd0);
            chk({tag, " err mem_en2"}, 32'(bus.mem_en), 32'd0);
            chk({tag, " err busy2"}, 32'(bus.cmd_busy), 32'd0);
            return;
        end
        for (int idx = 0; idx < BUDGET && k < v.exp_n; idx++) begin
            rdy = v.rdy_toggle ? ((idx % 4 == 0) || (idx % 4 == 3)) : 1'b1;
            bus.out_ready = rdy;
            if (v.poke && idx == 1) begin
                bus.cmd_start = 1'b1;
                bus.cmd_len   = '0;
            end
            if (v.poke && idx == 2) bus.cmd_start = 1'b0;
            #1;
            if (idx == 0) chk({tag, " busy"}, 32'(bus.cmd_busy), 32'd1);
            if (v.poke && idx == 2) chk({tag, " start while busy"}, 32'(bus.cmd_err), 32'd0);
            if (bus.mem_en) begin
                chk({tag, " mem_addr"}, 32'(bus.mem_addr), 32'((v.base + iss) % MEM_DEPTH));
                iss++;
            end
            if (hold) begin
                chk({tag, " hold valid"}, 32'(bus.out_valid), 32'd1);
                chk({tag, " hold data"}, bus.out_data, hold_d);
            end
            if (bus.out_valid) begin
                if (first < 0) first = idx;
                if (rdy) begin
                    chk({tag, " data"}, bus.out_data, fmt(mem[(v.base + k) % MEM_DEPTH]));
                    if (k == 0 && v.chk_first) chk({tag, " first word"}, bus.out_data, v.exp_first);
                    chk({tag, " last"}, 32'(bus.out_last), 32'(k == v.exp_n - 1));
                    chk({tag, " bytes"}, 32'(bus.out_bytes), (k == v.exp_n - 1) ? 32'(v.exp_lb) : 32'd4);
                    if (!v.rdy_toggle) chk({tag, " word timing"}, 32'(idx), 32'(2 + k));
                    k++;
                    hold = 1'b0;
                end else begin
                    hold   = 1'b1;
                    hold_d = bus.out_data;
                end
            end
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        #1;
        chk({tag, " word count"}, 32'(k), 32'(v.exp_n));
        chk({tag, " read count"}, 32'(iss), 32'(v.exp_n));
        chk({tag, " done"}, 32'(bus.cmd_done), 32'd1);
        chk({tag, " busy at done"}, 32'(bus.cmd_busy), 32'd0);
        chk({tag, " valid at done"}, 32'(bus.out_valid), 32'd0);
        @(negedge clk); #1;
        chk({tag, " done width"}, 32'(bus.cmd_done), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        bit seen;
        vecs[0] = '{10,  10,  1'b0, 1'b0, 1'b0, 3,   2, 1'b0, 32'h0};
        vecs[1] = '{0,   32,  1'b1, 1'b0, 1'b0, 8,   4, 1'b0, 32'h0};
        vecs[2] = '{206, 16,  1'b0, 1'b0, 1'b0, 4,   4, 1'b0, 32'h0};
        vecs[3] = '{0,   0,   1'b0, 1'b0, 1'b1, 0,   0, 1'b0, 32'h0};
        vecs[4] = '{0,   833, 1'b0, 1'b0, 1'b1, 0,   0, 1'b0, 32'h0};
        vecs[5] = '{208, 4,   1'b0, 1'b0, 1'b1, 0,   0, 1'b0, 32'h0};
        vecs[6] = '{50,  4,   1'b0, 1'b0, 1'b0, 1,   4, 1'b1, SWAP_WORD};
        vecs[7] = '{100, 832, 1'b0, 1'b1, 1'b0, 208, 4, 1'b0, 32'h0};
        vecs[8] = '{207, 5,   1'b0, 1'b0, 1'b0, 2,   1, 1'b0, 32'h0};
        vecs[9] = '{3,   7,   1'b1, 1'b0, 1'b0, 2,   3, 1'b0, 32'h0};

        for (int i = 0; i < MEM_DEPTH; i++) mem[i] = {8'hC0, 8'(i), 8'h5E, 8'(i)};
        mem[10] = 32'hA0A0_0000;
        mem[11] = 32'hA1A1_0001;
        mem[12] = 32'hA2A2_0002;
        mem[50] = 32'h1122_3344;

        bus.cmd_start = 1'b0;
        bus.cmd_base  = '0;
        bus.cmd_len   = '0;
        bus.abort     = 1'b0;
        bus.out_ready = 1'b1;
        rst = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rst busy", 32'(bus.cmd_busy), 32'd0);
        chk("rst done", 32'(bus.cmd_done), 32'd0);
        chk("rst err", 32'(bus.cmd_err), 32'd0);
        chk("rst mem_en", 32'(bus.mem_en), 32'd0);
        chk("rst mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst mem_wen", 32'(bus.mem_wen), 32'd0);
        chk("rst mem_wdata", bus.mem_wdata, 32'd0);
        chk("rst out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst out_last", 32'(bus.out_last), 32'd0);
        chk("rst out_bytes", 32'(bus.out_bytes), 32'd0);
        chk("rst out_data", bus.out_data, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < NVEC; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Abort after the third handshake, then a fresh one-word command
        start_cmd(0, 40);
        k = 0;
        for (int idx = 0; idx < 50 && k < 3; idx++) begin
            bus.out_ready = 1'b1;
            #1;
            if (bus.out_valid) begin
                chk("abort pre data", bus.out_data, fmt(mem[k]));
                k++;
            end
            @(negedge clk);
        end
        chk("abort pre count", 32'(k), 32'd3);
        bus.abort = 1'b1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        bus.abort = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        chk("abort valid", 32'(bus.out_valid), 32'd0);
        chk("abort mem_en", 32'(bus.mem_en), 32'd0);
        chk("abort busy", 32'(bus.cmd_busy), 32'd0);
        chk("abort done", 32'(bus.cmd_done), 32'd0);
        for (int idx = 0; idx < 3; idx++) begin
            @(negedge clk); #1;
            chk("abort quiet done", 32'(bus.cmd_done), 32'd0);
            chk("abort quiet valid", 32'(bus.out_valid), 32'd0);
        end
        @(negedge clk);
        run_vec('{5, 4, 1'b0, 1'b0, 1'b0, 1, 4, 1'b0, 32'h0}, "after abort");

        // Abort coincident with the final handshake suppresses cmd_done
        start_cmd(20, 8);
        seen = 1'b0;
        for (int idx = 0; idx < 50 && !seen; idx++) begin
            bus.out_ready = 1'b1;
            #1;
            if (bus.out_valid && bus.out_last) begin
                chk("final abort data", bus.out_data, fmt(mem[21]));
                bus.abort = 1'b1;
                seen = 1'b1;
            end
            @(negedge clk);
        end
        bus.abort = 1'b0;
        #1;
        chk("final abort seen", 32'(seen), 32'd1);
        chk("final abort done", 32'(bus.cmd_done), 32'd0);
        chk("final abort busy", 32'(bus.cmd_busy), 32'd0);
        chk("final abort valid", 32'(bus.out_valid), 32'd0);
        @(negedge clk); #1;
        chk("final abort done2", 32'(bus.cmd_done), 32'd0);

        // Asynchronous reset in the middle of a fetch
        start_cmd(0, 64);
        @(negedge clk); #1;
        chk("pre rst mem_en", 32'(bus.mem_en), 32'd1);
        chk("pre rst busy", 32'(bus.cmd_busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid rst busy", 32'(bus.cmd_busy), 32'd0);
        chk("mid rst mem_en", 32'(bus.mem_en), 32'd0);
        chk("mid rst mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("mid rst out_valid", 32'(bus.out_valid), 32'd0);
        chk("mid rst out_data", bus.out_data, 32'd0);
        chk("mid rst out_bytes", 32'(bus.out_bytes), 32'd0);
        chk("mid rst out_last", 32'(bus.out_last), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_vec(vecs[0], "after reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
